// File: rtl/vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_sync_gen
// Purpose  : VGA timing generator. Advances a horizontal pixel counter and a
//            vertical line counter on each pixel-enable pulse and decodes
//            active-low hsync/vsync, display-enable and line/frame strobes.
//            Default timing is 640x480 @ 800x525 totals.
// Ports    : clk          - system clock, all logic on posedge
//            i_sclr       - synchronous active-high clear
//            i_en         - pixel enable (one pulse per pixel, may be held)
//            o_hcnt       - current pixel column, 0..H_TOTAL-1
//            o_vcnt       - current line, 0..V_TOTAL-1
//            o_hsync      - horizontal sync, active low
//            o_vsync      - vertical sync, active low
//            o_disp_en    - high inside the visible region
//            o_line_end   - strobe on the enabled cycle of a line's last pixel
//            o_frame_end  - strobe on the enabled cycle of a frame's last pixel
// Options  : VGA_SYNC_REGOUT_EN - when defined, o_hcnt, o_vcnt, o_hsync,
//            o_vsync and o_disp_en are registered and lag the counters by one
//            enabled pixel; the strobes stay undelayed.
// Revision : 1.0 - initial release
// ============================================================================
module vga_sync_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HWIDTH   = 10,
    parameter int VWIDTH   = 10
) (
    input  logic              clk,
    input  logic              i_sclr,
    input  logic              i_en,
    output logic [HWIDTH-1:0] o_hcnt,
    output logic [VWIDTH-1:0] o_vcnt,
    output logic              o_hsync,
    output logic              o_vsync,
    output logic              o_disp_en,
    output logic              o_line_end,
    output logic              o_frame_end
);

    // Phase boundaries expressed as counter values at which each phase starts.
    localparam logic [HWIDTH-1:0] c_h_fp_start   = HWIDTH'(H_ACTIVE);
    localparam logic [HWIDTH-1:0] c_h_sync_start = HWIDTH'(H_ACTIVE + H_FP);
    localparam logic [HWIDTH-1:0] c_h_bp_start   = HWIDTH'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HWIDTH-1:0] c_h_last       = HWIDTH'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [VWIDTH-1:0] c_v_fp_start   = VWIDTH'(V_ACTIVE);
    localparam logic [VWIDTH-1:0] c_v_sync_start = VWIDTH'(V_ACTIVE + V_FP);
    localparam logic [VWIDTH-1:0] c_v_bp_start   = VWIDTH'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VWIDTH-1:0] c_v_last       = VWIDTH'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    typedef enum logic [1:0] {
        PH_ACT  = 2'd0,
        PH_FP   = 2'd1,
        PH_SYNC = 2'd2,
        PH_BP   = 2'd3
    } phase_t;

    logic [HWIDTH-1:0] r_hcnt;
    logic [VWIDTH-1:0] r_vcnt;
    phase_t            r_hph;
    phase_t            r_vph;

    logic              w_h_last;
    logic              w_v_last;
    logic [HWIDTH-1:0] w_hcnt_nxt;
    logic [VWIDTH-1:0] w_vcnt_nxt;

    assign w_h_last   = (r_hcnt == c_h_last);
    assign w_v_last   = (r_vcnt == c_v_last);
    assign w_hcnt_nxt = w_h_last ? '0 : r_hcnt + HWIDTH'(1);
    assign w_vcnt_nxt = w_v_last ? '0 : r_vcnt + VWIDTH'(1);

    // Counters and both phase FSMs. Phases move on the same enable that
    // brings the counter to a boundary, so phase and count stay aligned and
    // the decode below needs no extra comparators.
    always_ff @(posedge clk) begin
        if (i_sclr) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
            r_hph  <= PH_ACT;
            r_vph  <= PH_ACT;
        end else if (i_en) begin
            r_hcnt <= w_hcnt_nxt;
            case (r_hph)
                PH_ACT:  if (w_hcnt_nxt == c_h_fp_start)   r_hph <= PH_FP;
                PH_FP:   if (w_hcnt_nxt == c_h_sync_start) r_hph <= PH_SYNC;
                PH_SYNC: if (w_hcnt_nxt == c_h_bp_start)   r_hph <= PH_BP;
                PH_BP:   if (w_hcnt_nxt == '0)             r_hph <= PH_ACT;
                default: r_hph <= PH_ACT;
            endcase
            // Vertical state only moves on the enable that wraps the line.
            if (w_h_last) begin
                r_vcnt <= w_vcnt_nxt;
                case (r_vph)
                    PH_ACT:  if (w_vcnt_nxt == c_v_fp_start)   r_vph <= PH_FP;
                    PH_FP:   if (w_vcnt_nxt == c_v_sync_start) r_vph <= PH_SYNC;
                    PH_SYNC: if (w_vcnt_nxt == c_v_bp_start)   r_vph <= PH_BP;
                    PH_BP:   if (w_vcnt_nxt == '0)             r_vph <= PH_ACT;
                    default: r_vph <= PH_ACT;
                endcase
            end
        end
    end

    logic w_hsync;
    logic w_vsync;
    logic w_disp_en;

    assign w_hsync   = (r_hph != PH_SYNC);
    assign w_vsync   = (r_vph != PH_SYNC);
    assign w_disp_en = (r_hph == PH_ACT) && (r_vph == PH_ACT);

    // Strobes are gated by the enable so they are never wider than one clk,
    // even when the pixel enable is a sparse pulse.
    assign o_line_end  = i_en && w_h_last;
    assign o_frame_end = o_line_end && w_v_last;

`ifdef VGA_SYNC_REGOUT_EN
    logic [HWIDTH-1:0] r_hcnt_q;
    logic [VWIDTH-1:0] r_vcnt_q;
    logic              r_hsync_q;
    logic              r_vsync_q;
    logic              r_disp_en_q;

    // One enabled pixel of delay to line up with a single-stage pixel pipe.
    always_ff @(posedge clk) begin
        if (i_sclr) begin
            r_hcnt_q    <= '0;
            r_vcnt_q    <= '0;
            r_hsync_q   <= 1'b1;
            r_vsync_q   <= 1'b1;
            r_disp_en_q <= 1'b0;
        end else if (i_en) begin
            r_hcnt_q    <= r_hcnt;
            r_vcnt_q    <= r_vcnt;
            r_hsync_q   <= w_hsync;
            r_vsync_q   <= w_vsync;
            r_disp_en_q <= w_disp_en;
        end
    end

    assign o_hcnt    = r_hcnt_q;
    assign o_vcnt    = r_vcnt_q;
    assign o_hsync   = r_hsync_q;
    assign o_vsync   = r_vsync_q;
    assign o_disp_en = r_disp_en_q;
`else
    assign o_hcnt    = r_hcnt;
    assign o_vcnt    = r_vcnt;
    assign o_hsync   = w_hsync;
    assign o_vsync   = w_vsync;
    assign o_disp_en = w_disp_en;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_sync_gen
// Purpose  : Self-checking bench for vga_sync_gen. Horizontal timing uses the
//            standard 800-pixel line; the vertical timing is scaled down to a
//            30-line frame so full frames fit in a short run. A reference
//            model pushes expected outputs into a queue as each cycle is
//            driven; a monitor pops and compares them mid-cycle.
// Options  : VGA_SYNC_REGOUT_EN - selects the delayed-output reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_sync_gen;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 20;
    localparam int V_FP     = 3;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 5;
    localparam int HWIDTH   = 10;
    localparam int VWIDTH   = 10;
    localparam int HT       = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT       = V_ACTIVE + V_FP + V_SYNC + V_BP;

`ifdef VGA_SYNC_REGOUT_EN
    localparam bit c_rst_de      = 1'b0;
    localparam int c_first_hcnt  = 0;
    localparam int c_line_vcnt   = 0;
    localparam int c_hold_hcnt   = 299;
`else
    localparam bit c_rst_de      = 1'b1;
    localparam int c_first_hcnt  = 1;
    localparam int c_line_vcnt   = 1;
    localparam int c_hold_hcnt   = 300;
`endif

    logic              clk;
    logic              i_sclr;
    logic              i_en;
    logic [HWIDTH-1:0] o_hcnt;
    logic [VWIDTH-1:0] o_vcnt;
    logic              o_hsync;
    logic              o_vsync;
    logic              o_disp_en;
    logic              o_line_end;
    logic              o_frame_end;

    vga_sync_gen #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
        .HWIDTH   (HWIDTH),   .VWIDTH (VWIDTH)
    ) u_dut (
        .clk         (clk),
        .i_sclr      (i_sclr),
        .i_en        (i_en),
        .o_hcnt      (o_hcnt),
        .o_vcnt      (o_vcnt),
        .o_hsync     (o_hsync),
        .o_vsync     (o_vsync),
        .o_disp_en   (o_disp_en),
        .o_line_end  (o_line_end),
        .o_frame_end (o_frame_end)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int hcnt;
        int vcnt;
        bit hs;
        bit vs;
        bit de;
        bit le;
        bit fe;
    } exp_t;

    exp_t exp_q[$];
    int   asserts = 0;
    int   fails   = 0;
    int   le_seen = 0;
    int   fe_seen = 0;
    int   vs_low_seen = 0;

    // Reference model state.
    int   m_h = 0;
    int   m_v = 0;
    bit   m_valid = 1'b0;
`ifdef VGA_SYNC_REGOUT_EN
    int   d_h = 0;
    int   d_v = 0;
    bit   d_hs = 1'b1;
    bit   d_vs = 1'b1;
    bit   d_de = 1'b0;
`endif

    function automatic bit hs_of(int h);
        return !(h >= H_ACTIVE + H_FP && h < H_ACTIVE + H_FP + H_SYNC);
    endfunction

    function automatic bit vs_of(int v);
        return !(v >= V_ACTIVE + V_FP && v < V_ACTIVE + V_FP + V_SYNC);
    endfunction

    function automatic bit de_of(int h, int v);
        return (h < H_ACTIVE) && (v < V_ACTIVE);
    endfunction

    function automatic exp_t calc(int h, int v, bit en);
        exp_t e;
`ifdef VGA_SYNC_REGOUT_EN
        e.hcnt = d_h;
        e.vcnt = d_v;
        e.hs   = d_hs;
        e.vs   = d_vs;
        e.de   = d_de;
`else
        e.hcnt = h;
        e.vcnt = v;
        e.hs   = hs_of(h);
        e.vs   = vs_of(v);
        e.de   = de_of(h, v);
`endif
        e.le   = en && (h == HT - 1);
        e.fe   = e.le && (v == VT - 1);
        return e;
    endfunction

    // One clock of stimulus: drive at negedge, queue the expected mid-cycle
    // outputs, then advance the model at the posedge.
    task automatic step(input bit en, input bit sclr);
        @(negedge clk);
        i_en   = en;
        i_sclr = sclr;
        if (m_valid) exp_q.push_back(calc(m_h, m_v, en));
        @(posedge clk);
        if (sclr) begin
            m_h = 0;
            m_v = 0;
            m_valid = 1'b1;
`ifdef VGA_SYNC_REGOUT_EN
            d_h = 0; d_v = 0; d_hs = 1'b1; d_vs = 1'b1; d_de = 1'b0;
`endif
        end else if (en && m_valid) begin
`ifdef VGA_SYNC_REGOUT_EN
            d_h = m_h; d_v = m_v;
            d_hs = hs_of(m_h); d_vs = vs_of(m_v); d_de = de_of(m_h, m_v);
`endif
            if (m_h == HT - 1) begin
                m_h = 0;
                m_v = (m_v == VT - 1) ? 0 : m_v + 1;
            end else begin
                m_h = m_h + 1;
            end
        end
    endtask

    task automatic run_to(input int h, input int v, input int limit);
        int n = 0;
        while (!(m_h == h && m_v == v) && n < limit) begin
            step(1'b1, 1'b0);
            n++;
        end
        asserts++;
        if (!(m_h == h && m_v == v)) begin
            fails++;
            $display("FAIL run_to: reached (%0d,%0d), required (%0d,%0d) within %0d clks",
                     m_h, m_v, h, v, limit);
        end
    endtask

    // Scoreboard monitor: compares each queued expectation mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            asserts += 7;
            if (o_hcnt !== HWIDTH'(e.hcnt)) begin
                fails++; $display("FAIL hcnt: got %0d, required %0d", o_hcnt, e.hcnt);
            end
            if (o_vcnt !== VWIDTH'(e.vcnt)) begin
                fails++; $display("FAIL vcnt: got %0d, required %0d (hcnt %0d)", o_vcnt, e.vcnt, e.hcnt);
            end
            if (o_hsync !== e.hs) begin
                fails++; $display("FAIL hsync: got %b, required %b at hcnt %0d", o_hsync, e.hs, e.hcnt);
            end
            if (o_vsync !== e.vs) begin
                fails++; $display("FAIL vsync: got %b, required %b at vcnt %0d", o_vsync, e.vs, e.vcnt);
            end
            if (o_disp_en !== e.de) begin
                fails++; $display("FAIL disp_en: got %b, required %b at (%0d,%0d)", o_disp_en, e.de, e.hcnt, e.vcnt);
            end
            if (o_line_end !== e.le) begin
                fails++; $display("FAIL line_end: got %b, required %b at hcnt %0d", o_line_end, e.le, e.hcnt);
            end
            if (o_frame_end !== e.fe) begin
                fails++; $display("FAIL frame_end: got %b, required %b at (%0d,%0d)", o_frame_end, e.fe, e.hcnt, e.vcnt);
            end
            if (o_line_end === 1'b1)  le_seen++;
            if (o_frame_end === 1'b1) fe_seen++;
            if (o_vsync === 1'b0)     vs_low_seen++;
        end
    end

    task automatic test_reset;
        step(1'b0, 1'b1);
        #1;
        asserts += 6;
        if (o_hcnt !== '0)        begin fails++; $display("FAIL reset_hcnt: got %0d, required 0", o_hcnt); end
        if (o_vcnt !== '0)        begin fails++; $display("FAIL reset_vcnt: got %0d, required 0", o_vcnt); end
        if (o_hsync !== 1'b1)     begin fails++; $display("FAIL reset_hsync: got %b, required 1", o_hsync); end
        if (o_vsync !== 1'b1)     begin fails++; $display("FAIL reset_vsync: got %b, required 1", o_vsync); end
        if (o_disp_en !== c_rst_de) begin fails++; $display("FAIL reset_disp_en: got %b, required %b", o_disp_en, c_rst_de); end
        if (o_line_end !== 1'b0)  begin fails++; $display("FAIL reset_line_end: got %b, required 0", o_line_end); end
        // Idle clock must not advance; the first enable must.
        step(1'b0, 1'b0);
        #1;
        asserts++;
        if (o_hcnt !== '0) begin fails++; $display("FAIL idle_hcnt: got %0d, required 0", o_hcnt); end
        step(1'b1, 1'b0);
        #1;
        asserts++;
        if (o_hcnt !== HWIDTH'(c_first_hcnt)) begin
            fails++; $display("FAIL first_en_hcnt: got %0d, required %0d", o_hcnt, c_first_hcnt);
        end
        // Sparse enables, every second clock.
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0);
            step(1'b1, 1'b0);
        end
    endtask

    task automatic test_line;
        int le0 = le_seen;
        run_to(0, 1, 2 * HT);
        #1;
        asserts += 2;
        if (le_seen - le0 != 1) begin
            fails++; $display("FAIL line_end_count: got %0d, required 1", le_seen - le0);
        end
        if (o_vcnt !== VWIDTH'(c_line_vcnt)) begin
            fails++; $display("FAIL line_wrap_vcnt: got %0d, required %0d", o_vcnt, c_line_vcnt);
        end
    endtask

    task automatic test_hold;
        run_to(300, 1, 2 * HT);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0);
        #1;
        asserts++;
        if (o_hcnt !== HWIDTH'(c_hold_hcnt)) begin
            fails++; $display("FAIL hold_hcnt: got %0d, required %0d", o_hcnt, c_hold_hcnt);
        end
    endtask

    task automatic test_frame;
        int le0 = le_seen;
        int fe0 = fe_seen;
        int vs0 = vs_low_seen;
        run_to(0, 0, HT * VT + 10);
        asserts += 3;
        if (le_seen - le0 != VT - 1) begin
            fails++; $display("FAIL frame_line_ends: got %0d, required %0d", le_seen - le0, VT - 1);
        end
        if (fe_seen - fe0 != 1) begin
            fails++; $display("FAIL frame_end_count: got %0d, required 1", fe_seen - fe0);
        end
        if (vs_low_seen - vs0 != V_SYNC * HT) begin
            fails++; $display("FAIL vsync_low_clks: got %0d, required %0d", vs_low_seen - vs0, V_SYNC * HT);
        end
    endtask

    task automatic test_sclr_mid;
        run_to(700, V_ACTIVE + V_FP + V_SYNC + 2, HT * VT + 10);
        step(1'b1, 1'b1);
        #1;
        asserts += 5;
        if (o_hcnt !== '0)        begin fails++; $display("FAIL sclr_hcnt: got %0d, required 0", o_hcnt); end
        if (o_vcnt !== '0)        begin fails++; $display("FAIL sclr_vcnt: got %0d, required 0", o_vcnt); end
        if (o_hsync !== 1'b1)     begin fails++; $display("FAIL sclr_hsync: got %b, required 1", o_hsync); end
        if (o_vsync !== 1'b1)     begin fails++; $display("FAIL sclr_vsync: got %b, required 1", o_vsync); end
        if (o_line_end !== 1'b0 || o_frame_end !== 1'b0) begin
            fails++; $display("FAIL sclr_strobe: got %b%b, required 00", o_line_end, o_frame_end);
        end
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
    endtask

    initial begin
        i_en   = 1'b0;
        i_sclr = 1'b0;
        test_reset();
        test_line();
        test_hold();
        test_frame();
        test_sclr_mid();
        @(negedge clk);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Consumes the periodic pixel-enable pulse from the enable generator and produces VGA timing.
- Outputs: horizontal/vertical pixel counters, active-low hsync/vsync, display-enable, and line-end/frame-end strobes.
- Sits between the pixel-enable generator and the pixel/colour pipeline; all logic runs on the single system clock, and only enable-qualified cycles advance timing.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- HWIDTH, 10, width of horizontal counter; must hold H_TOTAL-1
- VWIDTH, 10, width of vertical counter; must hold V_TOTAL-1

Ports:
- clk  input  1  system clock, all logic on posedge
- i_sclr  input  1  synchronous active-high clear/reset
- i_en  input  1  pixel enable, one-cycle pulse per pixel (may be held high)
- o_hcnt  output  HWIDTH  current pixel column, 0..H_TOTAL-1
- o_vcnt  output  VWIDTH  current line, 0..V_TOTAL-1
- o_hsync  output  1  horizontal sync, active low
- o_vsync  output  1  vertical sync, active low
- o_disp_en  output  1  high while in visible region
- o_line_end  output  1  one-cycle strobe on the last pixel of a line
- o_frame_end  output  1  one-cycle strobe on the last pixel of a frame

Behaviour:
- Interface: one clock `clk`; reset is `i_sclr`, synchronous, active-high.
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Reset: when i_sclr=1 at posedge, then hcnt=0, vcnt=0, h phase=H_ACT, v phase=V_ACT.
  - Outputs after reset: o_hsync=1, o_vsync=1, o_disp_en=1, o_line_end=0, o_frame_end=0.
  - i_sclr has priority over i_en in the same cycle, including mid-line and mid-frame.
- Advance: state changes only on posedge with i_en=1. With i_en=0, all registers hold.
- Horizontal counter: hcnt increments by 1 per enable and wraps H_TOTAL-1 -> 0.
- Vertical counter: vcnt increments only when hcnt wraps, and itself wraps V_TOTAL-1 -> 0. On the frame boundary, hcnt and vcnt both return to 0 on the same enable.
- Horizontal phase FSM: H_ACT -> H_FP -> H_SYNC -> H_BP -> H_ACT.
  - Transitions on the enable where the next hcnt equals H_ACTIVE, H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC, and 0 respectively.
- Vertical phase FSM: V_ACT -> V_FP -> V_SYNC -> V_BP -> V_ACT, using the same rule on vcnt. It is evaluated only on hcnt-wrap enables.
- Output decode (default build): combinational from the registered phase state and counters, with zero latency relative to the counters.
  - o_hsync = 0 iff h phase == H_SYNC, i.e. hcnt in [656,752).
  - o_vsync = 0 iff v phase == V_SYNC, i.e. vcnt in [490,492).
  - o_disp_en = (h phase == H_ACT) && (v phase == V_ACT).
  - o_line_end = i_en && hcnt == H_TOTAL-1.
  - o_frame_end = o_line_end && vcnt == V_TOTAL-1.
  - Both strobes are high only in the enabled cycle, so at most one clk wide.
- i_en held high continuously: advances every clk, with no lost or doubled pixels.
- Zero-width parameter phases are not supported; every porch/sync parameter must be >= 1.

Optional Feature:
- Macro: VGA_SYNC_REGOUT_EN
- Defined: o_hsync, o_vsync, o_disp_en, o_hcnt and o_vcnt are registered and updated on the same enable as the counters, delayed by exactly one enabled pixel.
  - This aligns them with a one-stage pixel-data pipeline.
  - Reset values: hsync=1, vsync=1, disp_en=0, hcnt=0, vcnt=0.
  - o_line_end and o_frame_end remain undelayed.
- Undefined: outputs are combinational as described in Behaviour.

Test Plan:
- Reset with i_sclr=1 for 1 clk, then i_en pulsed every 2nd clk -> after reset hcnt=0, vcnt=0, hsync=1, vsync=1, disp_en=1; hcnt=1 only after the first i_en, not after the idle clk.
- i_en held high, 800 clks from reset -> disp_en falls at hcnt=640; hsync low from hcnt=656 through 751, high at 752; o_line_end high exactly at hcnt=799; next clk hcnt=0, vcnt=1.
- i_en high for 525*800 clks -> vsync low only for vcnt 490..491; disp_en=0 for all vcnt>=480; o_frame_end high exactly once at (799,524); next clk (0,0).
- i_en=0 held for 20 clks mid-line at hcnt=300 -> all outputs and counters unchanged.
- i_sclr=1 asserted together with i_en=1 at hcnt=700, vcnt=495 -> next clk hcnt=0, vcnt=0, hsync=1, vsync=1, no strobe.
- With VGA_SYNC_REGOUT_EN defined and i_en high -> o_hsync falls one clk later than in the default build (at the enable after hcnt=656); reset value of disp_en=0.
